// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation class shared by main control and ALU control decoder
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADDIU = 4'd0,
    ALU_SUBIU = 4'd1,
    ALU_ANDI  = 4'd2,
    ALU_ORI   = 4'd3,
    ALU_XORI  = 4'd4,
    ALU_SLTI  = 4'd5,
    ALU_SLTIU = 4'd6,
    ALU_RTYPE = 4'd7,
    ALU_BEQ   = 4'd8,
    ALU_BNE   = 4'd9,
    ALU_BLEZ  = 4'd10,
    ALU_BGTZ  = 4'd11,
    ALU_BLG   = 4'd12
  } alu_op_sel_t;

endpackage

// File: rtl/mips_controller.sv
// rtl/mips_controller.sv - multicycle MIPS main control FSM
module mips_controller
  import alu_pkg::*;
#(
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ir_31_to_26,
  input  logic [5:0]  ir_5_to_0,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        ir_write,
  output logic        jump_and_link,
  output logic        is_signed,
  output logic [1:0]  pc_source,
  output alu_op_sel_t alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        halted
);

  // Memory-address phase is two cycles so ALUOut is registered and stable
  // for a full cycle before it is driven onto the memory address.
  typedef enum logic [4:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_MEM_ADDR, S_MEM_ADDR2,
    S_LW_READ, S_LW_WAIT, S_LW_WB, S_SW_WRITE, S_R_EXEC, S_R_WB,
    S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(MEM_RD_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  alu_op_sel_t i_op, br_op;
  logic        i_zext, is_mult, is_jr;

  assign is_jr   = (ir_5_to_0 == 6'h08);
  assign is_mult = (ir_5_to_0 == 6'h18) || (ir_5_to_0 == 6'h19);

  // State and wait-counter registers with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Opcode to ALU class for I-type ALU ops and branches.
  always_comb begin
    i_op   = ALU_ADDIU;
    br_op  = ALU_BEQ;
    i_zext = 1'b0;
    case (ir_31_to_26)
      6'h10: i_op = ALU_SUBIU;
      6'h0C: begin i_op = ALU_ANDI; i_zext = 1'b1; end
      6'h0D: begin i_op = ALU_ORI;  i_zext = 1'b1; end
      6'h0E: begin i_op = ALU_XORI; i_zext = 1'b1; end
      6'h0A: i_op = ALU_SLTI;
      6'h0B: i_op = ALU_SLTIU;
      default: i_op = ALU_ADDIU;
    endcase
    case (ir_31_to_26)
      6'h05:   br_op = ALU_BNE;
      6'h06:   br_op = ALU_BLEZ;
      6'h07:   br_op = ALU_BGTZ;
      6'h01:   br_op = ALU_BLG;
      default: br_op = ALU_BEQ;
    endcase
  end

  // Next state, wait counter and Moore outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = 2'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    jump_and_link = 1'b0;
    is_signed     = 1'b0;
    pc_source     = 2'b00;
    alu_op        = ALU_ADDIU;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (cnt_q == WAIT_LAST) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        is_signed = 1'b1;
        case (ir_31_to_26)
          6'h23, 6'h2B:                             state_d = S_MEM_ADDR;
          6'h00:                                    state_d = is_jr ? S_JR : S_R_EXEC;
          6'h09, 6'h10, 6'h0C, 6'h0D, 6'h0E,
          6'h0A, 6'h0B:                             state_d = S_I_EXEC;
          6'h04, 6'h05, 6'h06, 6'h07, 6'h01:        state_d = S_BRANCH;
          6'h02:                                    state_d = S_JUMP;
          6'h03:                                    state_d = S_JAL;
          6'h3F:                                    state_d = S_HALT;
          default:                                  state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR, S_MEM_ADDR2: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        is_signed = 1'b1;
        if (state_q == S_MEM_ADDR) state_d = S_MEM_ADDR2;
        else state_d = (ir_31_to_26 == 6'h23) ? S_LW_READ : S_SW_WRITE;
      end
      S_LW_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = S_LW_WAIT;
      end
      S_LW_WAIT: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (cnt_q == WAIT_LAST) state_d = S_LW_WB;
        else cnt_d = cnt_q + 2'd1;
      end
      S_LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_SW_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
        state_d   = is_mult ? S_FETCH : S_R_WB;
      end
      S_R_WB: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EXEC, S_I_WB: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = i_op;
        is_signed = ~i_zext;
        reg_write = (state_q == S_I_WB);
        state_d   = (state_q == S_I_EXEC) ? S_I_WB : S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = br_op;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pc_write      = 1'b1;
        pc_source     = 2'b10;
        reg_write     = 1'b1;
        jump_and_link = 1'b1;
        state_d       = S_FETCH;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_controller.sv
// tb/tb_mips_controller.sv - randomized self-checking bench for mips_controller
module tb_mips_controller;
  import alu_pkg::*;

  typedef struct packed {
    logic        pc_write;
    logic        pc_write_cond;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        ir_write;
    logic        jump_and_link;
    logic        is_signed;
    logic [1:0]  pc_source;
    alu_op_sel_t alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        reg_write;
    logic        reg_dst;
    logic        halted;
  } ctl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op = 6'h00;
  logic [5:0] fn = 6'h00;

  logic        pcw [2], pcwc [2], iord [2], mr [2], mw [2], mtr [2], irw [2], jl [2];
  logic        iss [2], sa [2], rw [2], rd [2], hl [2];
  logic [1:0]  pcs [2], sb [2];
  alu_op_sel_t aop [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mips_controller #(.MEM_RD_LATENCY(g == 0 ? 1 : 3)) dut (
      .clk(clk), .rst(rst), .ir_31_to_26(op), .ir_5_to_0(fn),
      .pc_write(pcw[g]), .pc_write_cond(pcwc[g]), .i_or_d(iord[g]),
      .mem_read(mr[g]), .mem_write(mw[g]), .mem_to_reg(mtr[g]),
      .ir_write(irw[g]), .jump_and_link(jl[g]), .is_signed(iss[g]),
      .pc_source(pcs[g]), .alu_op(aop[g]), .alu_src_a(sa[g]),
      .alu_src_b(sb[g]), .reg_write(rw[g]), .reg_dst(rd[g]), .halted(hl[g])
    );
  end

  task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: list the cycles of one instruction straight from the
  // per-phase output rules, then index it by cycles since reset.
  function automatic ctl_t expect_at(input logic [5:0] o, input logic [5:0] f, input int lat, input int k);
    ctl_t q[$];
    ctl_t d, c;
    d = '0;
    d.alu_op = ALU_ADDIU;
    c = d; c.mem_read = 1; c.alu_src_b = 2'b01; q.push_back(c);
    for (int i = 0; i < lat; i++) begin
      c = d; c.mem_read = 1; c.alu_src_b = 2'b01;
      if (i == lat - 1) begin c.ir_write = 1; c.pc_write = 1; end
      q.push_back(c);
    end
    c = d; c.alu_src_b = 2'b11; c.is_signed = 1; q.push_back(c);
    if (o == 6'h23 || o == 6'h2B) begin
      c = d; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.is_signed = 1;
      q.push_back(c); q.push_back(c);
      if (o == 6'h23) begin
        c = d; c.mem_read = 1; c.i_or_d = 1;
        for (int i = 0; i <= lat; i++) q.push_back(c);
        c = d; c.reg_write = 1; c.mem_to_reg = 1; q.push_back(c);
      end else begin
        c = d; c.mem_write = 1; c.i_or_d = 1; q.push_back(c);
      end
    end else if (o == 6'h00 && f == 6'h08) begin
      c = d; c.pc_write = 1; c.pc_source = 2'b11; q.push_back(c);
    end else if (o == 6'h00) begin
      c = d; c.alu_src_a = 1; c.alu_op = ALU_RTYPE; q.push_back(c);
      if (f != 6'h18 && f != 6'h19) begin
        c.reg_write = 1; c.reg_dst = 1; q.push_back(c);
      end
    end else if (o inside {6'h09, 6'h10, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B}) begin
      c = d; c.alu_src_a = 1; c.alu_src_b = 2'b10;
      c.is_signed = !(o inside {6'h0C, 6'h0D, 6'h0E});
      case (o)
        6'h10: c.alu_op = ALU_SUBIU;
        6'h0C: c.alu_op = ALU_ANDI;
        6'h0D: c.alu_op = ALU_ORI;
        6'h0E: c.alu_op = ALU_XORI;
        6'h0A: c.alu_op = ALU_SLTI;
        6'h0B: c.alu_op = ALU_SLTIU;
        default: c.alu_op = ALU_ADDIU;
      endcase
      q.push_back(c);
      c.reg_write = 1; q.push_back(c);
    end else if (o inside {6'h04, 6'h05, 6'h06, 6'h07, 6'h01}) begin
      c = d; c.alu_src_a = 1; c.pc_write_cond = 1; c.pc_source = 2'b01;
      case (o)
        6'h04: c.alu_op = ALU_BEQ;
        6'h05: c.alu_op = ALU_BNE;
        6'h06: c.alu_op = ALU_BLEZ;
        6'h07: c.alu_op = ALU_BGTZ;
        default: c.alu_op = ALU_BLG;
      endcase
      q.push_back(c);
    end else if (o == 6'h02 || o == 6'h03) begin
      c = d; c.pc_write = 1; c.pc_source = 2'b10;
      if (o == 6'h03) begin c.reg_write = 1; c.jump_and_link = 1; end
      q.push_back(c);
    end else if (o == 6'h3F) begin
      c = d; c.halted = 1; q.push_back(c);
      if (k >= q.size()) return c;
    end
    return q[k % q.size()];
  endfunction

  logic [5:0] dir_op [10] = '{6'h00, 6'h23, 6'h0C, 6'h0A, 6'h01, 6'h00, 6'h3F, 6'h3E, 6'h2B, 6'h00};
  logic [5:0] dir_fn [10] = '{6'h21, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00, 6'h00, 6'h18};
  logic [5:0] legal [20] = '{6'h00, 6'h09, 6'h10, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h23, 6'h2B,
                             6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03, 6'h3F, 6'h00, 6'h23};
  logic [5:0] fsel [4] = '{6'h08, 6'h18, 6'h19, 6'h21};

  initial begin
    int k;
    int lats [2];
    int rst_len;
    lats[0] = 1;
    lats[1] = 3;
    for (int n = 0; n < 160; n++) begin
      if (n < 10) begin
        op = dir_op[n];
        fn = dir_fn[n];
      end else begin
        op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal[$urandom_range(0, 19)];
        fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fsel[$urandom_range(0, 3)];
      end
      rst = 1'b1;
      rst_len = (n == 0) ? 3 : $urandom_range(1, 3);
      k = 0;
      for (int cyc = 0; cyc < 32 + rst_len; cyc++) begin
        if (cyc >= rst_len) rst = (n >= 10 && $urandom_range(0, 24) == 0);
        @(posedge clk);
        k = rst ? 0 : k + 1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
          check_eq($sformatf("op%02h fn%02h L%0d k%0d", op, fn, lats[g], k),
                   {pcw[g], pcwc[g], iord[g], mr[g], mw[g], mtr[g], irw[g], jl[g], iss[g],
                    pcs[g], aop[g], sa[g], sb[g], rw[g], rd[g], hl[g]},
                   expect_at(op, fn, lats[g], k));
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
